hbridge_pwm_driver: RTL and testbench
=====================================

// Module: hbridge_pwm_driver
// PURPOSE
//  Downstream stage of the drive state machine. Takes per-side direction and duty commands,
//  generates glitch-free PWM enables and H-bridge input pins for both motors, and enforces
//  the 80% on-time cap, dead time on reversal, and a shaft-encoder stall watchdog.
//  Channel A = left motor (hbEnA/hbIn1/hbIn2, shaftPulseL).
//  Channel B = right motor (hbEnB/hbIn3/hbIn4, shaftPulseR).
// PARAMETERS
//  CLK_HZ        50_000_000  system clock frequency
//  PWM_HZ        80          PWM frequency; PERIOD = CLK_HZ/PWM_HZ cycles (625_000 by default; 20-bit counter)
//  DUTY_MAX_PCT  80          duty clamp, per H-bridge 2.5 A stall limit
//  DEADTIME_CYC  50_000      enable-off cycles inserted on fwd<->rev reversal (1 ms)
//  STALL_CYC     25_000_000  max cycles without a shaft pulse while driving (0.5 s)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  cmd_valid    in   1  command strobe; the command is captured on any cycle where this is high
//  cmd_dirA     in   2  00 coast, 01 fwd, 10 rev, 11 brake
//  cmd_dutyA    in   7  duty in percent, 0..127
//  cmd_dirB     in   2  as cmd_dirA
//  cmd_dutyB    in   7  as cmd_dutyA
//  shaftPulseL  in   1  async left encoder pulse
//  shaftPulseR  in   1  async right encoder pulse
//  hbEnA/hbEnB  out  1  bridge enables (PWM)
//  hbIn1..hbIn4 out  1  bridge direction pins
//  stallA/B     out  1  latched stall fault per channel
//  busy         out  1  pending command or dead time in progress
// BEHAVIOUR
//  Reset: all hb* outputs 0, stallA/B 0, busy 0, both channels COAST, period counter 0, pending cleared.
//  Period counter: 0..PERIOD-1, wraps to 0. Shared by both channels and never stalls.
//  Command capture: cmd_valid writes the pending register; last write wins; busy=1 while pending.
//  Coast/brake commands apply on the cycle after capture.
//  fwd/rev commands apply on the cycle the counter wraps to 0.
//    If capture and wrap coincide, the command applies at the following wrap.
//  Duty: effective = min(duty, DUTY_MAX_PCT); on_cnt = PERIOD*effective/100 (integer, floor).
//    on_cnt is computed once at apply time.
//  Per-channel FSM:
//    COAST: en=0, in=00.
//    BRAKE: en=1, in=11.
//    RUN: en = (count < on_cnt); duty 0 -> en never high.
//      Channel A pins: fwd in1/in2=01, rev=10.
//      Channel B pins: fwd in3/in4=10, rev=01.
//    DEAD: en=0, in=00 for exactly DEADTIME_CYC cycles, then RUN in the new direction.
//      Entered when a RUN fwd<->rev reversal is applied.
//      A coast or brake command during DEAD aborts it immediately.
//  Same-direction duty changes take effect at the wrap with no dead time.
//  Stall watchdog:
//    Shaft pulses pass through a 2-flop synchroniser plus a rising-edge detector.
//    The per-channel counter clears on each edge and increments only in RUN with on_cnt>0.
//    It saturates at STALL_CYC.
//    On reaching STALL_CYC: stallX=1, channel forced to COAST and held there.
//    Cleared only by an applied coast or brake command for that channel (stallX drops the same cycle).
//    fwd/rev commands to a stalled channel are ignored.
//  Outputs are registered: pins change 1 cycle after the FSM/compare decision.
// TESTING (sim params CLK_HZ=1000, PWM_HZ=10 -> PERIOD=100, DEADTIME_CYC=5, STALL_CYC=300)
//  1. A fwd duty 50 -> after wrap: hbEnA high for counts 0..49, low 50..99; in1=0, in2=1.
//  2. A fwd duty 100 -> en high exactly 80 of 100 cycles; duty 0 -> en stays 0.
//  3. A fwd 50, then rev 50 -> at wrap: en=0, in=00 for 5 cycles, then in1=1, in2=0, PWM resumes.
//  4. B fwd 40 with no shaftPulseR for 300 cycles -> stallB=1, hbEnB=0.
//     B fwd ignored; B coast -> stallB=0.
//  5. Brake issued mid-period -> next cycle en=1, in=11; cmd_valid on wrap cycle -> applied at next wrap.
//  6. rst asserted mid-DEAD and mid-RUN -> next cycle all outputs 0, busy 0, counter 0.

Source files
------------

// File: rtl/hbridge_pwm_driver.sv
// Dual H-bridge PWM driver: shared period counter, per-motor channel FSM with duty clamp,
// reversal dead time and encoder stall watchdog. Bridge pins are registered for glitch-free edges.

module HbridgeChannel #(
    parameter int         PERIOD       = 625_000,
    parameter int         CNT_W        = 20,
    parameter int         DUTY_MAX_PCT = 80,
    parameter int         DEADTIME_CYC = 50_000,
    parameter int         STALL_CYC    = 25_000_000,
    parameter logic [1:0] FWD_PINS     = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrap_i,
    input  logic [CNT_W-1:0] cntNext_i,
    input  logic             cmdValid_i,
    input  logic [1:0]       cmdDir_i,
    input  logic [6:0]       cmdDuty_i,
    input  logic             shaftPulse_i,
    output logic             en_o,
    output logic [1:0]       pins_o,
    output logic             stall_o,
    output logic             busy_o
);

    localparam int DEAD_W = $clog2(DEADTIME_CYC + 1);
    localparam int STALL_W = $clog2(STALL_CYC + 1);
    localparam int PROD_W = CNT_W + 7;
    localparam logic [1:0] DIR_FWD = 2'b01;
    localparam logic [1:0] DIR_REV = 2'b10;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    typedef enum logic [1:0] {COAST, BRAKE, RUN, DEAD} chanState_e;

    chanState_e         state_q, state_d;
    logic               fwd_q, fwd_d;
    logic [CNT_W-1:0]   onCnt_q, onCnt_d;
    logic [DEAD_W-1:0]  deadCnt_q, deadCnt_d;
    logic [STALL_W-1:0] stallCnt_q, stallCnt_d;
    logic               stall_q, stall_d;
    logic               pendValid_q, pendValid_d;
    logic [1:0]         pendDir_q, pendDir_d;
    logic [6:0]         pendDuty_q, pendDuty_d;
    logic [2:0]         shaftSync_q;
    logic               en_q, en_d;
    logic [1:0]         pins_q, pins_d;
    logic               busy_q, busy_d;
    logic               newFwd;
    logic               shaftEdge;

    function automatic logic [CNT_W-1:0] calcOnCnt(input logic [6:0] duty);
        logic [6:0]        eff;
        logic [PROD_W-1:0] prod;
        eff = (duty > 7'(DUTY_MAX_PCT)) ? 7'(DUTY_MAX_PCT) : duty;
        prod = PROD_W'(PERIOD) * PROD_W'(eff);
        return CNT_W'(prod / PROD_W'(100));
    endfunction

    assign shaftEdge = shaftSync_q[1] & ~shaftSync_q[2];

    always_comb begin
        state_d = state_q;
        fwd_d = fwd_q;
        onCnt_d = onCnt_q;
        deadCnt_d = deadCnt_q;
        stallCnt_d = stallCnt_q;
        stall_d = stall_q;
        pendValid_d = pendValid_q;
        pendDir_d = pendDir_q;
        pendDuty_d = pendDuty_q;
        newFwd = (pendDir_q == DIR_FWD);
        en_d = 1'b0;
        pins_d = 2'b00;

        if (state_q == DEAD) begin
            if (deadCnt_q == '0) begin
                state_d = RUN;
            end else begin
                deadCnt_d = deadCnt_q - DEAD_W'(1);
            end
        end

        if (shaftEdge) begin
            stallCnt_d = '0;
        end else if (state_q == RUN && onCnt_q != '0 && stallCnt_q != STALL_W'(STALL_CYC)) begin
            stallCnt_d = stallCnt_q + STALL_W'(1);
        end
        if (state_q == RUN && stallCnt_q == STALL_W'(STALL_CYC)) begin
            stall_d = 1'b1;
            state_d = COAST;
        end

        // Coast/brake act at once and clear a stall; fwd/rev wait for the period wrap.
        if (pendValid_q) begin
            if (pendDir_q != DIR_FWD && pendDir_q != DIR_REV) begin
                state_d = (pendDir_q == DIR_BRAKE) ? BRAKE : COAST;
                stall_d = 1'b0;
                stallCnt_d = '0;
                pendValid_d = 1'b0;
            end else if (wrap_i) begin
                pendValid_d = 1'b0;
                if (!stall_d) begin
                    onCnt_d = calcOnCnt(pendDuty_q);
                    fwd_d = newFwd;
                    if (state_q == RUN && newFwd != fwd_q) begin
                        state_d = DEAD;
                        deadCnt_d = DEAD_W'(DEADTIME_CYC - 1);
                    end else if (state_q != DEAD) begin
                        state_d = RUN;
                    end
                end
            end
        end

        if (cmdValid_i) begin
            pendValid_d = 1'b1;
            pendDir_d = cmdDir_i;
            pendDuty_d = cmdDuty_i;
        end

        case (state_d)
            BRAKE: begin
                en_d = 1'b1;
                pins_d = 2'b11;
            end
            RUN: begin
                en_d = (cntNext_i < onCnt_d);
                pins_d = fwd_d ? FWD_PINS : ~FWD_PINS;
            end
            default: begin
                en_d = 1'b0;
                pins_d = 2'b00;
            end
        endcase
        busy_d = pendValid_d | (state_d == DEAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COAST;
            fwd_q <= 1'b1;
            onCnt_q <= '0;
            deadCnt_q <= '0;
            stallCnt_q <= '0;
            stall_q <= 1'b0;
            pendValid_q <= 1'b0;
            pendDir_q <= 2'b00;
            pendDuty_q <= '0;
            shaftSync_q <= '0;
            en_q <= 1'b0;
            pins_q <= 2'b00;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fwd_q <= fwd_d;
            onCnt_q <= onCnt_d;
            deadCnt_q <= deadCnt_d;
            stallCnt_q <= stallCnt_d;
            stall_q <= stall_d;
            pendValid_q <= pendValid_d;
            pendDir_q <= pendDir_d;
            pendDuty_q <= pendDuty_d;
            shaftSync_q <= {shaftSync_q[1:0], shaftPulse_i};
            en_q <= en_d;
            pins_q <= pins_d;
            busy_q <= busy_d;
        end
    end

    assign en_o = en_q;
    assign pins_o = pins_q;
    assign stall_o = stall_q;
    assign busy_o = busy_q;

endmodule

module hbridge_pwm_driver #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int PWM_HZ       = 80,
    parameter int DUTY_MAX_PCT = 80,
    parameter int DEADTIME_CYC = 50_000,
    parameter int STALL_CYC    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_dirA,
    input  logic [6:0] cmd_dutyA,
    input  logic [1:0] cmd_dirB,
    input  logic [6:0] cmd_dutyB,
    input  logic       shaftPulseL,
    input  logic       shaftPulseR,
    output logic       hbEnA,
    output logic       hbEnB,
    output logic       hbIn1,
    output logic       hbIn2,
    output logic       hbIn3,
    output logic       hbIn4,
    output logic       stallA,
    output logic       stallB,
    output logic       busy
);

    localparam int PERIOD = CLK_HZ / PWM_HZ;
    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;
    logic             busyA, busyB;

    always_comb begin
        wrap = (cnt_q == CNT_W'(PERIOD - 1));
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    HbridgeChannel #(
        .PERIOD(PERIOD), .CNT_W(CNT_W), .DUTY_MAX_PCT(DUTY_MAX_PCT),
        .DEADTIME_CYC(DEADTIME_CYC), .STALL_CYC(STALL_CYC), .FWD_PINS(2'b01)
    ) chanA (
        .clk(clk), .rst(rst), .wrap_i(wrap), .cntNext_i(cnt_d),
        .cmdValid_i(cmd_valid), .cmdDir_i(cmd_dirA), .cmdDuty_i(cmd_dutyA),
        .shaftPulse_i(shaftPulseL), .en_o(hbEnA), .pins_o({hbIn1, hbIn2}),
        .stall_o(stallA), .busy_o(busyA)
    );

    HbridgeChannel #(
        .PERIOD(PERIOD), .CNT_W(CNT_W), .DUTY_MAX_PCT(DUTY_MAX_PCT),
        .DEADTIME_CYC(DEADTIME_CYC), .STALL_CYC(STALL_CYC), .FWD_PINS(2'b10)
    ) chanB (
        .clk(clk), .rst(rst), .wrap_i(wrap), .cntNext_i(cnt_d),
        .cmdValid_i(cmd_valid), .cmdDir_i(cmd_dirB), .cmdDuty_i(cmd_dutyB),
        .shaftPulse_i(shaftPulseR), .en_o(hbEnB), .pins_o({hbIn3, hbIn4}),
        .stall_o(stallB), .busy_o(busyB)
    );

    assign busy = busyA | busyB;

endmodule

// File: tb/tb_hbridge_pwm_driver.sv
// Directed bench for hbridge_pwm_driver with PERIOD=100, dead time 5, stall limit 300.
// A command driven in the cycle where the period count is c is applied at c+1 (coast/brake) and shows on the pins at c+2.

module tb_hbridge_pwm_driver;

    localparam logic [1:0] DIR_COAST = 2'b00;
    localparam logic [1:0] DIR_FWD = 2'b01;
    localparam logic [1:0] DIR_REV = 2'b10;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_dirA = 2'b00;
    logic [6:0] cmd_dutyA = 7'd0;
    logic [1:0] cmd_dirB = 2'b00;
    logic [6:0] cmd_dutyB = 7'd0;
    logic       shaftPulseL;
    logic       shaftPulseR = 1'b0;
    logic       hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4, stallA, stallB, busy;

    int          tbCnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  pulseDiv = 4'd0;
    logic [99:0] trace;
    logic [1:0]  pinsZero;
    logic [8:0]  allOut;

    hbridge_pwm_driver #(
        .CLK_HZ(1000), .PWM_HZ(10), .DUTY_MAX_PCT(80), .DEADTIME_CYC(5), .STALL_CYC(300)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid),
        .cmd_dirA(cmd_dirA), .cmd_dutyA(cmd_dutyA), .cmd_dirB(cmd_dirB), .cmd_dutyB(cmd_dutyB),
        .shaftPulseL(shaftPulseL), .shaftPulseR(shaftPulseR),
        .hbEnA(hbEnA), .hbEnB(hbEnB), .hbIn1(hbIn1), .hbIn2(hbIn2), .hbIn3(hbIn3), .hbIn4(hbIn4),
        .stallA(stallA), .stallB(stallB), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference period counter; a negedge sample of the pins belongs to this count.
    always @(posedge clk) tbCnt <= rst ? 0 : ((tbCnt == 99) ? 0 : tbCnt + 1);

    // Left encoder keeps turning: a rising edge every 16 cycles.
    always @(negedge clk) pulseDiv <= pulseDiv + 4'd1;
    assign shaftPulseL = pulseDiv[3];

    assign allOut = {hbEnA, hbIn1, hbIn2, hbEnB, hbIn3, hbIn4, stallA, stallB, busy};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] dirA, input logic [6:0] dutyA,
                                 input logic [1:0] dirB, input logic [6:0] dutyB);
        cmd_dirA = dirA;
        cmd_dutyA = dutyA;
        cmd_dirB = dirB;
        cmd_dutyB = dutyB;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitForCount(input int target);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tbCnt == target) break;
        end
    endtask

    task automatic capturePeriod(output logic [99:0] enTrace, output logic [1:0] pinsAtZero);
        waitForCount(0);
        pinsAtZero = {hbIn1, hbIn2};
        for (int i = 0; i < 100; i++) begin
            enTrace[i] = hbEnA;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: bench did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        $display("[TB] hbridge_pwm_driver bench start");
        repeat (3) @(negedge clk);
        checkOutput("reset outputs", allOut, 9'd0);
        rst = 1'b0;

        // Channel A forward 50 %: high for counts 0..49.
        waitForCount(10);
        applyStimulus(DIR_FWD, 7'd50, DIR_COAST, 7'd0);
        checkOutput("busy pending", busy, 1'b1);
        capturePeriod(trace, pinsZero);
        checkOutput("fwd50 pins", pinsZero, 2'b01);
        checkOutput("fwd50 en@0", trace[0], 1'b1);
        checkOutput("fwd50 en@49", trace[49], 1'b1);
        checkOutput("fwd50 en@50", trace[50], 1'b0);
        checkOutput("fwd50 en@99", trace[99], 1'b0);
        checkOutput("fwd50 on count", $countones(trace), 50);
        checkOutput("B coast", {hbEnB, hbIn3, hbIn4}, 3'b000);

        // Duty 100 clamps to 80 %; duty 0 never enables.
        applyStimulus(DIR_FWD, 7'd100, DIR_COAST, 7'd0);
        capturePeriod(trace, pinsZero);
        checkOutput("fwd100 on count", $countones(trace), 80);
        checkOutput("fwd100 en@79", trace[79], 1'b1);
        checkOutput("fwd100 en@80", trace[80], 1'b0);
        applyStimulus(DIR_FWD, 7'd0, DIR_COAST, 7'd0);
        capturePeriod(trace, pinsZero);
        checkOutput("duty0 on count", $countones(trace), 0);
        checkOutput("duty0 pins", pinsZero, 2'b01);

        // Reversal: 5 dead cycles then reverse PWM.
        applyStimulus(DIR_FWD, 7'd50, DIR_COAST, 7'd0);
        waitForCount(0);
        waitForCount(10);
        applyStimulus(DIR_REV, 7'd50, DIR_COAST, 7'd0);
        waitForCount(99);
        checkOutput("pre reversal", {hbEnA, hbIn1, hbIn2}, 3'b001);
        waitForCount(0);
        checkOutput("dead@0", {hbEnA, hbIn1, hbIn2}, 3'b000);
        checkOutput("dead busy", busy, 1'b1);
        waitForCount(4);
        checkOutput("dead@4", {hbEnA, hbIn1, hbIn2}, 3'b000);
        waitForCount(5);
        checkOutput("rev@5", {hbEnA, hbIn1, hbIn2}, 3'b110);
        checkOutput("rev busy", busy, 1'b0);
        waitForCount(49);
        checkOutput("rev en@49", hbEnA, 1'b1);
        waitForCount(50);
        checkOutput("rev en@50", hbEnA, 1'b0);

        // Brake mid-period, then a command captured on the wrap cycle.
        waitForCount(30);
        applyStimulus(DIR_BRAKE, 7'd0, DIR_COAST, 7'd0);
        checkOutput("brake not yet", {hbEnA, hbIn1, hbIn2}, 3'b110);
        @(negedge clk);
        checkOutput("brake applied", {hbEnA, hbIn1, hbIn2}, 3'b111);
        waitForCount(99);
        applyStimulus(DIR_FWD, 7'd50, DIR_COAST, 7'd0);
        checkOutput("wrap cmd held", {hbEnA, hbIn1, hbIn2}, 3'b111);
        checkOutput("wrap cmd busy", busy, 1'b1);
        waitForCount(0);
        checkOutput("wrap cmd applied", {hbEnA, hbIn1, hbIn2}, 3'b101);
        waitForCount(50);
        checkOutput("wrap cmd en@50", {hbEnA, hbIn1, hbIn2}, 3'b001);

        // Right encoder silent: stall after 300 RUN cycles.
        waitForCount(10);
        applyStimulus(DIR_FWD, 7'd50, DIR_FWD, 7'd40);
        waitForCount(0);
        checkOutput("B fwd pins", {hbEnB, hbIn3, hbIn4}, 3'b110);
        waitForCount(0);
        waitForCount(0);
        waitForCount(99);
        checkOutput("stallB early@299", stallB, 1'b0);
        waitForCount(0);
        checkOutput("stallB early@300", {stallB, hbEnB}, 2'b01);
        @(negedge clk);
        checkOutput("stallB set", {stallB, hbEnB, hbIn3, hbIn4}, 4'b1000);
        checkOutput("stallA clear", stallA, 1'b0);
        waitForCount(10);
        applyStimulus(DIR_FWD, 7'd50, DIR_FWD, 7'd40);
        waitForCount(0);
        checkOutput("B fwd ignored", {stallB, hbEnB, hbIn3, hbIn4}, 4'b1000);
        waitForCount(5);
        applyStimulus(DIR_FWD, 7'd50, DIR_COAST, 7'd0);
        checkOutput("stallB before coast", stallB, 1'b1);
        @(negedge clk);
        checkOutput("stallB cleared", stallB, 1'b0);

        // Reset in DEAD, then a fresh period, then reset in RUN.
        waitForCount(10);
        applyStimulus(DIR_REV, 7'd50, DIR_COAST, 7'd0);
        waitForCount(0);
        waitForCount(2);
        checkOutput("pre-reset dead busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset in dead", allOut, 9'd0);
        rst = 1'b0;
        waitForCount(10);
        applyStimulus(DIR_FWD, 7'd50, DIR_COAST, 7'd0);
        waitForCount(99);
        checkOutput("post reset coast", {hbEnA, hbIn1, hbIn2}, 3'b000);
        waitForCount(0);
        checkOutput("post reset wrap", {hbEnA, hbIn1, hbIn2}, 3'b101);
        waitForCount(20);
        checkOutput("pre-reset run", {hbEnA, hbIn1, hbIn2}, 3'b101);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset in run", allOut, 9'd0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
